// File: rtl/instruction_fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_state_t : fetch controller states
//   fetch_fault_t : fault code attached to each instruction handed to decode
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        HOLD      = 2'd2,
        DROP      = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        FETCH_OK         = 2'b00,
        FETCH_MISALIGNED = 2'b01,
        FETCH_ACCESS     = 2'b10
    } fetch_fault_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Takes the current PC, fetches the word at that address over a
// valid/ready request bus with a separate response channel, and holds the
// result until decode accepts it. Acceptance pulses pc_write_enable so the
// program counter advances. At most one request is ever outstanding.
//
// Ports:
//   clock, reset        core clock, synchronous active-high reset
//   pc                  current program counter
//   flush               redirect pulse; pc carries the new target next cycle
//   pc_write_enable     high in the cycle decode accepts a non-flushed instruction
//   imem_req_*          read request (valid/ready/addr)
//   imem_resp_*         read response (valid/data/error)
//   inst_valid/ready    handshake to decode
//   inst, inst_pc       held instruction word and its address
//   inst_fault          00 none, 01 misaligned, 10 bus access fault
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  pc_write_enable,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_error,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [1:0]            inst_fault
);

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;

    logic [INST_WIDTH-1:0] r_inst;
    logic [ADDR_WIDTH-1:0] r_inst_pc;
    fetch_fault_t          r_inst_fault;

    logic                  w_aligned;
    logic                  w_req_valid;
    logic                  w_pc_we;
    logic                  w_inst_valid;
    logic                  w_cap_pc;
    logic                  w_cap_mis;
    logic                  w_cap_resp;

    assign w_aligned = (pc[1:0] == 2'b00);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode. Flush is checked first in every
    // state so it always wins over a simultaneous accept or response.
    always_comb begin
        w_next_state = r_state;
        w_req_valid  = 1'b0;
        w_pc_we      = 1'b0;
        w_inst_valid = 1'b0;
        w_cap_pc     = 1'b0;
        w_cap_mis    = 1'b0;
        w_cap_resp   = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Responses seen here are stale (e.g. from before reset) and ignored.
                if (!flush) begin
                    if (w_aligned) begin
                        w_req_valid = 1'b1;
                        if (imem_req_ready) begin
                            w_cap_pc     = 1'b1;
                            w_next_state = WAIT_RESP;
                        end
                    end else begin
                        // Misaligned PC never reaches the bus; it becomes a faulted
                        // instruction for decode to trap on.
                        w_cap_pc     = 1'b1;
                        w_cap_mis    = 1'b1;
                        w_next_state = HOLD;
                    end
                end
            end
            WAIT_RESP: begin
                if (flush) begin
                    w_next_state = imem_resp_valid ? IDLE : DROP;
                end else if (imem_resp_valid) begin
                    w_cap_resp   = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                w_inst_valid = 1'b1;
                if (flush) begin
                    w_next_state = IDLE;
                end else if (inst_ready) begin
                    w_pc_we      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DROP: begin
                // Swallow the response that was in flight when the flush came.
                if (imem_resp_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Held-instruction register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_fault <= FETCH_OK;
        end else begin
            if (w_cap_pc) begin
                r_inst_pc <= pc;
            end
            if (w_cap_mis) begin
                r_inst       <= '0;
                r_inst_fault <= FETCH_MISALIGNED;
            end
            if (w_cap_resp) begin
                r_inst       <= imem_resp_error ? '0 : imem_resp_data;
                r_inst_fault <= imem_resp_error ? FETCH_ACCESS : FETCH_OK;
            end
        end
    end

    // All outputs are forced low while reset is asserted, including the
    // first reset cycle before the registers have been cleared.
    assign imem_req_valid  = w_req_valid  & ~reset;
    assign imem_req_addr   = reset ? '0 : pc;
    assign pc_write_enable = w_pc_we      & ~reset;
    assign inst_valid      = w_inst_valid & ~reset;
    assign inst            = reset ? '0 : r_inst;
    assign inst_pc         = reset ? '0 : r_inst_pc;
    assign inst_fault      = reset ? 2'b00 : r_inst_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        pc_write_enable;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_error;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;

    int tests;
    int failed;
    int pwe_count;

    instruction_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
        .clock           (clk),
        .reset           (reset),
        .pc              (pc),
        .flush           (flush),
        .pc_write_enable (pc_write_enable),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_error (imem_resp_error),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed
    // and outputs checked mid-cycle, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_reqv"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_addr"}, imem_req_addr, 32'd0);
        chk({tag, "_ivld"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_pwe"},  {31'd0, pc_write_enable}, 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_ipc"},  inst_pc, 32'd0);
        chk({tag, "_flt"},  {30'd0, inst_fault}, 32'd0);
    endtask

    initial begin
        tests = 0; failed = 0; pwe_count = 0;
        reset = 1'b1; pc = 32'h0; flush = 1'b0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0; imem_resp_error = 1'b0; inst_ready = 1'b1;

        // ---- Reset, then basic zero-wait fetch ----
        tick();
        settle();
        chk_all_zero("rst");

        reset = 1'b0;                      // cycle 1: request
        settle();
        chk("c1_reqv", {31'd0, imem_req_valid}, 32'd1);
        chk("c1_addr", imem_req_addr, 32'h0);
        tick();
        imem_req_ready = 1'b0;             // cycle 2: response
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        settle();
        chk("c2_reqv", {31'd0, imem_req_valid}, 32'd0);
        chk("c2_ivld", {31'd0, inst_valid}, 32'd0);
        tick();
        imem_resp_valid = 1'b0;            // cycle 3: hand to decode
        settle();
        chk("c3_ivld", {31'd0, inst_valid}, 32'd1);
        chk("c3_inst", inst, 32'h0000_0013);
        chk("c3_ipc",  inst_pc, 32'h0);
        chk("c3_flt",  {30'd0, inst_fault}, 32'd0);
        chk("c3_pwe",  {31'd0, pc_write_enable}, 32'd1);
        tick();
        pc = 32'h4; inst_ready = 1'b0;     // cycle 4: next request
        settle();
        chk("c4_reqv", {31'd0, imem_req_valid}, 32'd1);
        chk("c4_addr", imem_req_addr, 32'h4);
        chk("c4_pwe",  {31'd0, pc_write_enable}, 32'd0);

        // ---- Stalls on request, response and decode ----
        for (int i = 0; i < 3; i++) begin
            chk("st_reqv_hold", {31'd0, imem_req_valid}, 32'd1);
            chk("st_addr_hold", imem_req_addr, 32'h4);
            tick();
            settle();
        end
        imem_req_ready = 1'b1;
        settle();
        chk("st_reqv_hs", {31'd0, imem_req_valid}, 32'd1);
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("st_wait_reqv", {31'd0, imem_req_valid}, 32'd0);
            chk("st_wait_ivld", {31'd0, inst_valid}, 32'd0);
            tick();
        end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0093;
        tick();
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("st_hold_ivld", {31'd0, inst_valid}, 32'd1);
            chk("st_hold_inst", inst, 32'h00A0_0093);
            chk("st_hold_ipc",  inst_pc, 32'h4);
            if (pc_write_enable) pwe_count++;
            tick();
        end
        inst_ready = 1'b1;
        settle();
        chk("st_acc_pwe", {31'd0, pc_write_enable}, 32'd1);
        if (pc_write_enable) pwe_count++;
        tick();
        inst_ready = 1'b0;
        settle();
        chk("st_post_ivld", {31'd0, inst_valid}, 32'd0);
        if (pc_write_enable) pwe_count++;
        chk("st_pwe_count", pwe_count, 32'd1);

        // ---- Misaligned PC ----
        pc = 32'h0000_0102; imem_req_ready = 1'b1;
        settle();
        chk("mis_reqv", {31'd0, imem_req_valid}, 32'd0);
        tick();
        imem_req_ready = 1'b0;
        settle();
        chk("mis_ivld", {31'd0, inst_valid}, 32'd1);
        chk("mis_inst", inst, 32'h0);
        chk("mis_flt",  {30'd0, inst_fault}, 32'd1);
        chk("mis_ipc",  inst_pc, 32'h102);
        chk("mis_pwe0", {31'd0, pc_write_enable}, 32'd0);
        inst_ready = 1'b1;
        settle();
        chk("mis_pwe1", {31'd0, pc_write_enable}, 32'd1);
        tick();

        // ---- Bus error response ----
        inst_ready = 1'b0; pc = 32'h8; imem_req_ready = 1'b1;
        settle();
        chk("err_reqv", {31'd0, imem_req_valid}, 32'd1);
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_error = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0; imem_resp_error = 1'b0; imem_resp_data = 32'h0;
        settle();
        chk("err_ivld", {31'd0, inst_valid}, 32'd1);
        chk("err_inst", inst, 32'h0);
        chk("err_flt",  {30'd0, inst_fault}, 32'd2);
        chk("err_ipc",  inst_pc, 32'h8);
        chk("err_pwe0", {31'd0, pc_write_enable}, 32'd0);
        inst_ready = 1'b1;
        settle();
        chk("err_pwe1", {31'd0, pc_write_enable}, 32'd1);
        tick();

        // ---- Flush in WAIT_RESP, stale response dropped ----
        inst_ready = 1'b0; pc = 32'hC; imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; flush = 1'b1;
        settle();
        chk("fw_pwe_f", {31'd0, pc_write_enable}, 32'd0);
        tick();
        flush = 1'b0; pc = 32'h40;
        settle();
        chk("fw_d1_reqv", {31'd0, imem_req_valid}, 32'd0);
        chk("fw_d1_ivld", {31'd0, inst_valid}, 32'd0);
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_AAAA;
        settle();
        chk("fw_d2_reqv", {31'd0, imem_req_valid}, 32'd0);
        chk("fw_d2_ivld", {31'd0, inst_valid}, 32'd0);
        chk("fw_d2_pwe",  {31'd0, pc_write_enable}, 32'd0);
        tick();
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        settle();
        chk("fw_new_reqv", {31'd0, imem_req_valid}, 32'd1);
        chk("fw_new_addr", imem_req_addr, 32'h40);
        chk("fw_new_ivld", {31'd0, inst_valid}, 32'd0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0513;
        tick();
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        settle();
        chk("fw_after_inst", inst, 32'h0000_0513);
        chk("fw_after_ipc",  inst_pc, 32'h40);

        // ---- Flush in HOLD together with accept ----
        flush = 1'b1; inst_ready = 1'b1;
        settle();
        chk("fh_pwe",  {31'd0, pc_write_enable}, 32'd0);
        chk("fh_ivld", {31'd0, inst_valid}, 32'd1);
        tick();
        flush = 1'b0; inst_ready = 1'b0;
        settle();
        chk("fh_next_ivld", {31'd0, inst_valid}, 32'd0);

        // ---- Reset during WAIT_RESP, stale response ignored in IDLE ----
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; reset = 1'b1;
        settle();
        chk_all_zero("rw");
        tick();
        reset = 1'b0; pc = 32'h44;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_AAAA;
        settle();
        chk("rw_st_reqv", {31'd0, imem_req_valid}, 32'd1);
        chk("rw_st_ivld", {31'd0, inst_valid}, 32'd0);
        chk("rw_st_inst", inst, 32'h0);
        tick();
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        settle();
        chk("rw_after_ivld", {31'd0, inst_valid}, 32'd0);
        chk("rw_after_reqv", {31'd0, imem_req_valid}, 32'd1);

        // ---- Flush with simultaneous response, then flush in IDLE ----
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        flush = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
        tick();
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        settle();
        chk("fr_ivld", {31'd0, inst_valid}, 32'd0);
        chk("fr_idle_flush_reqv", {31'd0, imem_req_valid}, 32'd0);
        flush = 1'b0;
        settle();
        chk("fr_idle_reqv", {31'd0, imem_req_valid}, 32'd1);
        chk("fr_inst_kept", inst, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Consumes the current PC from the program counter and fetches the instruction word at that address over the instruction-memory request/response bus.
- Holds the fetched word until decode accepts it, then pulses pc_write_enable so the program counter advances.
- Handles redirect (flush), in-flight response discard, misaligned-PC faults and bus errors.
- At most one outstanding memory request at any time.

Parameters:
- ADDR_WIDTH, 32, width of pc and imem address.
- INST_WIDTH, 32, width of instruction word.

Ports:
- clock  in  1  core clock; one clock domain; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  ADDR_WIDTH  current program counter value.
- flush  in  1  redirect pulse; pc holds the new target from the next cycle.
- pc_write_enable  out  1  high for exactly the cycle decode accepts a non-flushed instruction.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  read address (word aligned).
- imem_resp_valid  in  1  response valid, earliest one cycle after request handshake.
- imem_resp_data  in  INST_WIDTH  instruction word.
- imem_resp_error  in  1  access fault for this response.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst  out  INST_WIDTH  held instruction word (0 on any fault).
- inst_pc  out  ADDR_WIDTH  address of held instruction.
- inst_fault  out  2  00 none, 01 misaligned fetch, 10 bus access fault.

Behaviour:
- States: IDLE, WAIT_RESP, HOLD, DROP.
- Reset (synchronous, reset high at a rising edge) forces IDLE and clears inst, inst_pc and inst_fault to 0. In the cycle(s) reset is high, every output is 0.
- IDLE, pc[1:0]==0, flush=0:
  - Drive imem_req_valid=1 and imem_req_addr=pc combinationally.
  - On imem_req_ready=1, capture inst_pc<=pc and go to WAIT_RESP.
  - The bus permits withdrawing valid before handshake; only valid&ready transfers.
- IDLE, pc[1:0]!=0, flush=0: no request. Capture inst<=0, inst_pc<=pc, inst_fault<=01, go to HOLD.
- IDLE, flush=1: no request; stay IDLE.
- IDLE, imem_resp_valid=1: ignored. This covers stale responses left over after reset.
- WAIT_RESP:
  - imem_req_valid=0.
  - On imem_resp_valid with flush=0: capture inst<=resp_error?0:resp_data and inst_fault<=resp_error?10:00, go to HOLD.
  - Flush with no response: go to DROP.
  - Flush together with a response: discard the response, go to IDLE.
- DROP: on imem_resp_valid, discard the response and go to IDLE. A further flush keeps the state at DROP.
- HOLD:
  - inst_valid=1. inst, inst_pc and inst_fault are stable while inst_ready=0.
  - inst_ready=1 and flush=0: pc_write_enable=1 combinationally in the same cycle, then go to IDLE.
  - flush=1, with or without inst_ready: discard the instruction, pc_write_enable=0, go to IDLE.
- Flush always wins over a simultaneous accept or response.
- pc_write_enable is asserted only in HOLD. The core's redirect logic owns PC writes on flush.
- Latency with a zero-wait memory:
  - request cycle N, response N+1, inst_valid N+2, next request N+3.
  - Throughput is one instruction per 3 cycles plus memory wait states.
- Faulted instructions are handed to decode like normal ones; trap handling is downstream.

Decomposition:
- Shared package: fetch_state_t enum (IDLE/WAIT_RESP/HOLD/DROP) and fetch_fault_t encodings FETCH_OK=2'b00, FETCH_MISALIGNED=2'b01, FETCH_ACCESS=2'b10.
- Single module, no sub-module. The held-instruction register is only a few flops.

Test Plan:
- Reset, pc=0x0000_0000, ready=1, resp one cycle later with data 0x00000013, inst_ready=1:
  - imem_req_addr=0x0 in cycle 1, inst_valid in cycle 3 with inst=0x00000013 and inst_pc=0x0.
  - pc_write_enable pulses in cycle 3; with pc=0x4 the next request appears in cycle 4.
- imem_req_ready held low 3 cycles, then response delayed 2 cycles, inst_ready low 2 cycles:
  - Request stays valid until the handshake.
  - inst is stable through the stall.
  - Exactly one pc_write_enable pulse.
- pc=0x0000_0102: no imem_req_valid; inst_valid with inst=0, inst_fault=01, inst_pc=0x102.
- Response with imem_resp_error=1, data 0xDEADBEEF: inst=0, inst_fault=10; pc_write_enable pulses on accept.
- Flush in WAIT_RESP, stale response (data 0xAAAAAAAA) 2 cycles later:
  - Stale data is never presented and pc_write_enable stays 0.
  - The new request to the redirected pc issues the cycle after the drop.
- Flush in HOLD with inst_ready=1 in the same cycle: pc_write_enable=0, inst_valid drops next cycle. Reset during WAIT_RESP: a stale resp_valid in IDLE is ignored.
